// File: rtl/dmem_port_arbiter.sv
// Store drain FIFO plus single-port data memory arbiter for two in-order load lanes.
// Define LD_FWD_EN to forward queued/incoming store data to hazardous loads.
module dmem_port_arbiter #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned HI_WM      = 6,
    parameter int unsigned LO_WM      = 2,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_vld0,
    input  logic [31:0] st_addr0,
    input  logic [31:0] st_data0,
    input  logic        st_vld1,
    input  logic [31:0] st_addr1,
    input  logic [31:0] st_data1,
    output logic        st_ready,
    input  logic        ld_req0,
    input  logic [31:0] ld_addr0,
    input  logic        ld_req1,
    input  logic [31:0] ld_addr1,
    output logic        ld_gnt0,
    output logic        ld_gnt1,
    output logic        ld_rvld,
    output logic        ld_rlane,
    output logic [31:0] ld_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        ovf_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {ModeNormal, ModeDrain} mode_e;

    logic [31:0]   fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, free_slots, post_deq;
    logic [SW-1:0] starve_q, starve_d;
    mode_e         mode_q, mode_d;
    logic          ovf_q, ovf_d;
    logic          acc0, acc1, haz0, haz1, elig0, elig1;
    logic          drain, wr, rd, fwd_now;
    logic [31:0]   fwd_data;
    logic          mem_we_d, mem_re_d, mem_we_q, mem_re_q;
    logic [31:0]   mem_addr_d, mem_wdata_d, mem_addr_q, mem_wdata_q;
    logic          p1_vld_q, p1_lane_q, p1_fwd_q, p2_vld_q, p2_lane_q, p2_fwd_q;
    logic [31:0]   p1_fdata_q, p2_fdata_q;
`ifdef LD_FWD_EN
    logic [31:0]   fdata0, fdata1;
`endif

    // Acceptance looks only at current occupancy; a same-cycle dequeue does not free a slot.
    assign free_slots = CW'(DEPTH) - count_q;
    assign st_ready   = free_slots >= CW'(2);
    assign acc0       = st_vld0 && (free_slots != '0);
    assign acc1       = st_vld1 && (free_slots > CW'(acc0));

    // Head-to-tail scan, then incoming lanes, so the last hit is the youngest store.
    always_comb begin
        haz0 = 1'b0;
        haz1 = 1'b0;
`ifdef LD_FWD_EN
        fdata0 = '0;
        fdata1 = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (fifo_addr_q[rd_ptr_q + PW'(i)] == ld_addr0) begin
                    haz0 = 1'b1;
`ifdef LD_FWD_EN
                    fdata0 = fifo_data_q[rd_ptr_q + PW'(i)];
`endif
                end
                if (fifo_addr_q[rd_ptr_q + PW'(i)] == ld_addr1) begin
                    haz1 = 1'b1;
`ifdef LD_FWD_EN
                    fdata1 = fifo_data_q[rd_ptr_q + PW'(i)];
`endif
                end
            end
        end
        if (acc0 && st_addr0 == ld_addr0) begin
            haz0 = 1'b1;
`ifdef LD_FWD_EN
            fdata0 = st_data0;
`endif
        end
        if (acc0 && st_addr0 == ld_addr1) begin
            haz1 = 1'b1;
`ifdef LD_FWD_EN
            fdata1 = st_data0;
`endif
        end
        if (acc1 && st_addr1 == ld_addr0) begin
            haz0 = 1'b1;
`ifdef LD_FWD_EN
            fdata0 = st_data1;
`endif
        end
        if (acc1 && st_addr1 == ld_addr1) begin
            haz1 = 1'b1;
`ifdef LD_FWD_EN
            fdata1 = st_data1;
`endif
        end
    end

`ifdef LD_FWD_EN
    assign elig0 = 1'b1;
    assign elig1 = 1'b1;
`else
    assign elig0 = !haz0;
    assign elig1 = !haz1;
`endif

    always_comb begin
        drain = (mode_q == ModeDrain) || (count_q >= CW'(HI_WM)) ||
                (starve_q >= SW'(STARVE_MAX));
        ld_gnt0  = 1'b0;
        ld_gnt1  = 1'b0;
        fwd_now  = 1'b0;
        fwd_data = '0;
        if (!drain) begin
            if (ld_req0) ld_gnt0 = elig0;
            else         ld_gnt1 = ld_req1 && elig1;
        end
`ifdef LD_FWD_EN
        fwd_now  = (ld_gnt0 && haz0) || (ld_gnt1 && haz1);
        fwd_data = ld_gnt0 ? fdata0 : fdata1;
`endif
        rd = (ld_gnt0 || ld_gnt1) && !fwd_now;
        wr = (count_q != '0) && !rd;

        post_deq = count_q - CW'(wr);
        mode_d   = (drain && post_deq > CW'(LO_WM)) ? ModeDrain : ModeNormal;

        if (count_q == '0 || wr)              starve_d = '0;
        else if (starve_q < SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
        else                                  starve_d = starve_q;

        count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(wr);
        rd_ptr_d = rd_ptr_q + PW'(wr);
        wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);
        ovf_d    = ovf_q || (st_vld0 && !acc0) || (st_vld1 && !acc1);

        mem_we_d    = wr;
        mem_re_d    = rd;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (wr) begin
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
        end else if (rd) begin
            mem_addr_d = ld_gnt0 ? ld_addr0 : ld_addr1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) begin
            fifo_addr_q[wr_ptr_q] <= st_addr0;
            fifo_data_q[wr_ptr_q] <= st_data0;
        end
        if (acc1) begin
            fifo_addr_q[wr_ptr_q + PW'(acc0)] <= st_addr1;
            fifo_data_q[wr_ptr_q + PW'(acc0)] <= st_data1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            mode_q      <= ModeNormal;
            ovf_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p1_vld_q    <= 1'b0;
            p1_lane_q   <= 1'b0;
            p1_fwd_q    <= 1'b0;
            p1_fdata_q  <= '0;
            p2_vld_q    <= 1'b0;
            p2_lane_q   <= 1'b0;
            p2_fwd_q    <= 1'b0;
            p2_fdata_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p1_vld_q    <= ld_gnt0 || ld_gnt1;
            p1_lane_q   <= ld_gnt1;
            p1_fwd_q    <= fwd_now;
            p1_fdata_q  <= fwd_data;
            p2_vld_q    <= p1_vld_q;
            p2_lane_q   <= p1_lane_q;
            p2_fwd_q    <= p1_fwd_q;
            p2_fdata_q  <= p1_fdata_q;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ovf_err   = ovf_q;
    assign ld_rvld   = p2_vld_q;
    assign ld_rlane  = p2_lane_q;
    assign ld_rdata  = !p2_vld_q ? '0 : (p2_fwd_q ? p2_fdata_q : mem_rdata);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter; RAM model returns addr ^ 0xA5A50000.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_vld0, st_vld1, ld_req0, ld_req1;
    logic [31:0] st_addr0, st_data0, st_addr1, st_data1, ld_addr0, ld_addr1;
    logic        st_ready, ld_gnt0, ld_gnt1, ld_rvld, ld_rlane, mem_we, mem_re, ovf_err;
    logic [31:0] ld_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    int          total = 0;
    int          bad = 0;

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .st_vld0(st_vld0), .st_addr0(st_addr0), .st_data0(st_data0),
        .st_vld1(st_vld1), .st_addr1(st_addr1), .st_data1(st_data1),
        .st_ready(st_ready),
        .ld_req0(ld_req0), .ld_addr0(ld_addr0), .ld_req1(ld_req1), .ld_addr1(ld_addr1),
        .ld_gnt0(ld_gnt0), .ld_gnt1(ld_gnt1),
        .ld_rvld(ld_rvld), .ld_rlane(ld_rlane), .ld_rdata(ld_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_addr ^ 32'hA5A5_0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_vld0 = 0; st_vld1 = 0; ld_req0 = 0; ld_req1 = 0;
        st_addr0 = 0; st_data0 = 0; st_addr1 = 0; st_data1 = 0;
        ld_addr0 = 0; ld_addr1 = 0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_reset();
        rst = 0; idle(); #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rst_st_ready got=%0b exp=1", st_ready); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b exp=0", ovf_err); end
        total++; if ({mem_we, mem_re, ld_rvld, ld_gnt0, ld_gnt1} !== 5'b0) begin
            bad++; $display("FAIL rst_ctrl got=%b exp=00000", {mem_we, mem_re, ld_rvld, ld_gnt0, ld_gnt1});
        end
        total++; if (mem_addr !== 32'h0 || ld_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_data got=%h/%h exp=0/0", mem_addr, ld_rdata);
        end
        rst = 1;
        tick();
        // A load in flight when reset hits must not respond.
        ld_req0 = 1; ld_addr0 = 32'h44; #1;
        total++; if (ld_gnt0 !== 1'b1) begin bad++; $display("FAIL rst_pre_gnt got=%0b exp=1", ld_gnt0); end
        tick(); ld_req0 = 0;
        rst = 0; #1;
        total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL rst_mem_re got=%0b exp=0", mem_re); end
        rst = 1;
        tick();
        total++; if (ld_rvld !== 1'b0) begin bad++; $display("FAIL rst_discard got=%0b exp=0", ld_rvld); end
        tick();
    endtask

    task automatic test_dual_store();
        st_vld0 = 1; st_addr0 = 32'h10; st_data0 = 32'h11;
        st_vld1 = 1; st_addr1 = 32'h20; st_data1 = 32'h22; #1;
        total++; if (ld_gnt0 !== 1'b0 || st_ready !== 1'b1) begin
            bad++; $display("FAIL dual_enq gnt/rdy got=%0b%0b exp=01", ld_gnt0, st_ready);
        end
        tick(); idle(); #1;
        tick();
        total++; if ({mem_we, mem_re} !== 2'b10 || mem_addr !== 32'h10 || mem_wdata !== 32'h11) begin
            bad++; $display("FAIL dual_wr0 got=%b %h %h exp=10 10 11", {mem_we, mem_re}, mem_addr, mem_wdata);
        end
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h22) begin
            bad++; $display("FAIL dual_wr1 got=%b %h %h exp=1 20 22", mem_we, mem_addr, mem_wdata);
        end
        tick();
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL dual_empty got=%0b exp=0", mem_we); end
    endtask

    task automatic test_load_basic();
        ld_req0 = 1; ld_addr0 = 32'h40; #1;
        total++; if ({ld_gnt0, ld_gnt1} !== 2'b10) begin
            bad++; $display("FAIL ld_gnt got=%b exp=10", {ld_gnt0, ld_gnt1});
        end
        tick(); ld_req0 = 0; #1;
        total++; if ({mem_we, mem_re} !== 2'b01 || mem_addr !== 32'h40 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL ld_mem got=%b %h %h exp=01 40 0", {mem_we, mem_re}, mem_addr, mem_wdata);
        end
        total++; if (ld_rvld !== 1'b0) begin bad++; $display("FAIL ld_early got=%0b exp=0", ld_rvld); end
        tick();
        total++; if (ld_rvld !== 1'b1 || ld_rlane !== 1'b0 || ld_rdata !== 32'hA5A5_0040) begin
            bad++; $display("FAIL ld_resp got=%0b %0b %h exp=1 0 a5a50040", ld_rvld, ld_rlane, ld_rdata);
        end
        tick();
        total++; if (ld_rvld !== 1'b0) begin bad++; $display("FAIL ld_resp_end got=%0b exp=0", ld_rvld); end
    endtask

    task automatic test_back_to_back();
        ld_req0 = 1; ld_addr0 = 32'h100; ld_req1 = 1; ld_addr1 = 32'h200; #1;
        total++; if ({ld_gnt0, ld_gnt1} !== 2'b10) begin
            bad++; $display("FAIL b2b_order got=%b exp=10", {ld_gnt0, ld_gnt1});
        end
        tick(); ld_req0 = 0; #1;
        total++; if ({ld_gnt0, ld_gnt1} !== 2'b01) begin
            bad++; $display("FAIL b2b_lane1 got=%b exp=01", {ld_gnt0, ld_gnt1});
        end
        tick(); ld_req1 = 0; #1;
        total++; if (mem_re !== 1'b1 || mem_addr !== 32'h200) begin
            bad++; $display("FAIL b2b_mem1 got=%0b %h exp=1 200", mem_re, mem_addr);
        end
        total++; if (ld_rvld !== 1'b1 || ld_rlane !== 1'b0 || ld_rdata !== 32'hA5A5_0100) begin
            bad++; $display("FAIL b2b_resp0 got=%0b %0b %h exp=1 0 a5a50100", ld_rvld, ld_rlane, ld_rdata);
        end
        tick();
        total++; if (ld_rvld !== 1'b1 || ld_rlane !== 1'b1 || ld_rdata !== 32'hA5A5_0200) begin
            bad++; $display("FAIL b2b_resp1 got=%0b %0b %h exp=1 1 a5a50200", ld_rvld, ld_rlane, ld_rdata);
        end
        tick();
    endtask

    task automatic test_drain();
        ld_req0 = 1; ld_addr0 = 32'h300;
        for (int k = 0; k < 3; k++) begin
            st_vld0 = 1; st_addr0 = 32'h1000 + 32'h20 * k; st_data0 = k;
            st_vld1 = 1; st_addr1 = 32'h1010 + 32'h20 * k; st_data1 = k + 8; #1;
            total++; if (ld_gnt0 !== 1'b1) begin
                bad++; $display("FAIL drain_fill_gnt[%0d] got=%0b exp=1", k, ld_gnt0);
            end
            tick();
        end
        st_vld0 = 0; st_vld1 = 0; #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (ld_gnt0 !== 1'b0) begin
                bad++; $display("FAIL drain_nogrant[%0d] got=%0b exp=0", k, ld_gnt0);
            end
            tick();
            total++; if (mem_we !== 1'b1 || mem_addr !== 32'h1000 + 32'h10 * k) begin
                bad++; $display("FAIL drain_wr[%0d] got=%0b %h exp=1 %h", k, mem_we, mem_addr,
                                32'h1000 + 32'h10 * k);
            end
        end
        total++; if (ld_gnt0 !== 1'b1) begin bad++; $display("FAIL drain_resume got=%0b exp=1", ld_gnt0); end
        ld_req0 = 0;
        repeat (4) tick();
    endtask

    task automatic test_starve();
        st_vld0 = 1; st_addr0 = 32'h2000; st_data0 = 32'h55;
        ld_req0 = 1; ld_addr0 = 32'h500; #1;
        tick(); st_vld0 = 0; #1;
        for (int k = 1; k <= 15; k++) begin
            total++; if (ld_gnt0 !== 1'b1 || mem_we !== 1'b0) begin
                bad++; $display("FAIL starve_wait[%0d] got=%0b%0b exp=10", k, ld_gnt0, mem_we);
            end
            tick();
        end
        total++; if (ld_gnt0 !== 1'b0) begin bad++; $display("FAIL starve_force got=%0b exp=0", ld_gnt0); end
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h55) begin
            bad++; $display("FAIL starve_wr got=%0b %h %h exp=1 2000 55", mem_we, mem_addr, mem_wdata);
        end
        total++; if (ld_gnt0 !== 1'b1) begin bad++; $display("FAIL starve_resume got=%0b exp=1", ld_gnt0); end
        ld_req0 = 0;
        repeat (3) tick();
    endtask

    task automatic test_hazard();
        st_vld0 = 1; st_addr0 = 32'h80; st_data0 = 32'hAB; #1;
        tick(); st_vld0 = 0;
        ld_req0 = 1; ld_addr0 = 32'h80; #1;
`ifdef LD_FWD_EN
        total++; if (ld_gnt0 !== 1'b1) begin bad++; $display("FAIL haz_fwd_gnt got=%0b exp=1", ld_gnt0); end
        tick(); ld_req0 = 0; #1;
        total++; if (mem_re !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hAB) begin
            bad++; $display("FAIL haz_fwd_mem got=%0b%0b %h %h exp=01 80 ab", mem_re, mem_we, mem_addr, mem_wdata);
        end
        tick();
        total++; if (ld_rvld !== 1'b1 || ld_rlane !== 1'b0 || ld_rdata !== 32'hAB) begin
            bad++; $display("FAIL haz_fwd_resp got=%0b %0b %h exp=1 0 ab", ld_rvld, ld_rlane, ld_rdata);
        end
`else
        total++; if (ld_gnt0 !== 1'b0) begin bad++; $display("FAIL haz_hold got=%0b exp=0", ld_gnt0); end
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hAB) begin
            bad++; $display("FAIL haz_wr got=%0b %h %h exp=1 80 ab", mem_we, mem_addr, mem_wdata);
        end
        total++; if (ld_gnt0 !== 1'b1) begin bad++; $display("FAIL haz_gnt got=%0b exp=1", ld_gnt0); end
        tick(); ld_req0 = 0; #1;
        total++; if (mem_re !== 1'b1 || mem_addr !== 32'h80) begin
            bad++; $display("FAIL haz_rd got=%0b %h exp=1 80", mem_re, mem_addr);
        end
        tick();
        total++; if (ld_rvld !== 1'b1 || ld_rdata !== 32'hA5A5_0080) begin
            bad++; $display("FAIL haz_resp got=%0b %h exp=1 a5a50080", ld_rvld, ld_rdata);
        end
`endif
        repeat (3) tick();
        // Both incoming lanes hit the load address; lane 1 is the youngest.
        st_vld0 = 1; st_addr0 = 32'h90; st_data0 = 32'h5A;
        st_vld1 = 1; st_addr1 = 32'h90; st_data1 = 32'h6B;
        ld_req0 = 1; ld_addr0 = 32'h90; #1;
`ifdef LD_FWD_EN
        total++; if (ld_gnt0 !== 1'b1) begin bad++; $display("FAIL inc_fwd_gnt got=%0b exp=1", ld_gnt0); end
        tick(); idle(); #1;
        tick();
        total++; if (ld_rvld !== 1'b1 || ld_rdata !== 32'h6B) begin
            bad++; $display("FAIL inc_fwd_resp got=%0b %h exp=1 6b", ld_rvld, ld_rdata);
        end
`else
        total++; if (ld_gnt0 !== 1'b0) begin bad++; $display("FAIL inc_hold0 got=%0b exp=0", ld_gnt0); end
        tick(); st_vld0 = 0; st_vld1 = 0; #1;
        total++; if (ld_gnt0 !== 1'b0) begin bad++; $display("FAIL inc_hold1 got=%0b exp=0", ld_gnt0); end
        tick();
        total++; if (ld_gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h5A) begin
            bad++; $display("FAIL inc_wr0 got=%0b %0b %h exp=0 1 5a", ld_gnt0, mem_we, mem_wdata);
        end
        tick();
        total++; if (ld_gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h6B) begin
            bad++; $display("FAIL inc_wr1 got=%0b %0b %h exp=1 1 6b", ld_gnt0, mem_we, mem_wdata);
        end
`endif
        idle();
        repeat (4) tick();
    endtask

    task automatic test_overflow();
        int seen80 = 0;
        int seen90 = 0;
        ld_req0 = 1; ld_addr0 = 32'h600;
        for (int k = 0; k < 4; k++) begin
            st_vld0 = 1; st_addr0 = 32'h3000 + 32'h20 * k; st_data0 = k;
            st_vld1 = 1; st_addr1 = 32'h3010 + 32'h20 * k; st_data1 = k; #1;
            total++; if (st_ready !== 1'b1) begin
                bad++; $display("FAIL ovf_ready[%0d] got=%0b exp=1", k, st_ready);
            end
            tick();
        end
        st_vld0 = 1; st_addr0 = 32'h3080; st_data0 = 32'h80;
        st_vld1 = 1; st_addr1 = 32'h3090; st_data1 = 32'h90; #1;
        total++; if (st_ready !== 1'b0 || ovf_err !== 1'b0) begin
            bad++; $display("FAIL ovf_full got=%0b%0b exp=00", st_ready, ovf_err);
        end
        tick(); idle(); #1;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", ovf_err); end
        repeat (20) begin
            if (mem_we && mem_addr == 32'h3080) seen80++;
            if (mem_we && mem_addr == 32'h3090) seen90++;
            tick();
        end
        total++; if (seen80 != 1 || seen90 != 0) begin
            bad++; $display("FAIL ovf_drop got=%0d/%0d exp=1/0", seen80, seen90);
        end
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovf_err); end
        do_reset();
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", ovf_err); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_dual_store();
        test_load_basic();
        test_back_to_back();
        test_drain();
        test_starve();
        do_reset();
        test_hazard();
        do_reset();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Sits between the store buffer and the single-port data memory. Queues committed stores (up to two per cycle) in a drain FIFO and arbitrates the one memory port between those stores and two load lanes. Returns load data in order, and guarantees stores drain under load pressure using a watermark and a starvation counter.

Parameters:
DEPTH, 8, drain FIFO entries (power of 2, >=4)
HI_WM, 6, occupancy at or above which DRAIN mode is entered
LO_WM, 2, occupancy at or below which DRAIN mode exits
STARVE_MAX, 15, cycles a non-empty FIFO may go without a write before DRAIN is forced

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
st_vld0  in  1  committed store, lane 0 (older)
st_addr0  in  32  store address, lane 0
st_data0  in  32  store data, lane 0
st_vld1  in  1  committed store, lane 1 (younger)
st_addr1  in  32  store address, lane 1
st_data1  in  32  store data, lane 1
st_ready  out  1  FIFO has >=2 free slots (combinational from occupancy)
ld_req0  in  1  load request, lane 0 (older); held until granted
ld_addr0  in  32  load address, lane 0
ld_req1  in  1  load request, lane 1; held until granted
ld_addr1  in  32  load address, lane 1
ld_gnt0  out  1  lane 0 granted this cycle (combinational)
ld_gnt1  out  1  lane 1 granted this cycle (combinational)
ld_rvld  out  1  load response valid
ld_rlane  out  1  lane of the response
ld_rdata  out  32  load response data
mem_we  out  1  memory write enable (registered)
mem_re  out  1  memory read enable (registered)
mem_addr  out  32  memory address (registered)
mem_wdata  out  32  memory write data (registered)
mem_rdata  in  32  synchronous RAM read data, valid the cycle after mem_re
ovf_err  out  1  sticky: a store arrived when no slot was free

Behaviour:
- Reset (async, rst=0):
  - FIFO empty, pointers and count 0, starve counter 0, mode NORMAL.
  - All outputs 0 except st_ready=1.
  - An in-flight load response is discarded.
- Enqueue:
  - Lane 0 is written before lane 1; both may arrive in one cycle.
  - Only lane 1 valid: it takes the single next slot.
  - Pointers wrap modulo DEPTH.
  - Any store arriving with no free slot is dropped and sets ovf_err; ovf_err clears only on reset.
- Simultaneous enqueue and dequeue in one cycle are legal. Count updates by (enq - deq).
- One memory operation per cycle, decided in cycle N:
  - Grant pulses in cycle N.
  - mem_* are valid in N+1.
  - ld_rvld, ld_rlane and ld_rdata (=mem_rdata) are valid in N+2.
- Mode FSM:
  - NORMAL: grant an eligible load, lane 0 before lane 1. Otherwise, if the FIFO is non-empty, write the head store.
  - NORMAL->DRAIN when count >= HI_WM, or when the starve counter reaches STARVE_MAX.
  - DRAIN: write the head store every cycle and grant no loads.
  - DRAIN->NORMAL when the post-dequeue count <= LO_WM, or the FIFO is empty.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no store is written.
  - Clears on any store write or when the FIFO is empty.
- Load eligibility:
  - A load is hazardous when its address equals any valid FIFO entry, or a store arriving in the same cycle.
  - A hazardous load is not granted (it is handled by the optional feature).
- Ordering: lane 1 may be granted only when lane 0 is not requesting. At most one grant per cycle.
- A load granted in N always returns in N+2, never reordered, with back-to-back responses allowed.
- mem_we and mem_re are never high together. mem_wdata=0 on reads.

Optional Feature:
LD_FWD_EN.
- Defined:
  - A hazardous load is eligible and granted under the normal rules, without using the memory port; the port is free for the head store that cycle.
  - Data comes from the youngest match, searched in this order: incoming lane 1 (youngest), incoming lane 0, then FIFO entries from tail down to head.
  - The response still appears exactly 2 cycles after grant, in order.
- Not defined: a hazardous load waits until no match remains.

Test Plan:
- Reset, then st_vld0 and st_vld1 in one cycle (A=0x10/D=0x11, A=0x20/D=0x22), no loads -> writes to 0x10 then 0x20 on consecutive cycles; count returns to 0.
- ld_req0=1, addr 0x40, empty FIFO -> ld_gnt0 in N; mem_re=1, addr 0x40 in N+1; ld_rvld=1, ld_rlane=0, data=mem_rdata in N+2.
- Continuous loads while 6 stores are queued (count=HI_WM) -> DRAIN; 4 consecutive writes with no grants until count=2; then loads resume.
- Continuous lane-0 loads with 1 queued store -> after 15 starved cycles, one store is written, then NORMAL resumes.
- Store 0x80/0xAB queued, load 0x80: without LD_FWD_EN, no grant until the store writes, then read; with it, grant immediately and ld_rdata=0xAB at N+2 with mem_re=0.
- Fill the FIFO with 8 stores, then assert st_vld0 -> st_ready=0, store dropped, ovf_err=1 until rst.
